// File: rtl/alt_vipvfr131_common_raster_count.sv
// Three-level raster position counter (ticks -> x -> y) with per-frame shadowed limits.
// Optional interlaced field scan enabled by defining ALT_VIPVFR_RASTER_FIELD_EN.
module alt_vipvfr131_common_raster_count #(
  parameter int TICKS_WIDTH  = 2,
  parameter int X_WIDTH      = 12,
  parameter int Y_WIDTH      = 12,
  parameter int AUTO_RESTART = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   enable,
`ifdef ALT_VIPVFR_RASTER_FIELD_EN
  input  logic                   field,
`endif
  input  logic [TICKS_WIDTH-1:0] max_ticks,
  input  logic [X_WIDTH-1:0]     max_x,
  input  logic [Y_WIDTH-1:0]     max_y,
  output logic [TICKS_WIDTH-1:0] ticks,
  output logic [X_WIDTH-1:0]     x,
  output logic [Y_WIDTH-1:0]     y,
  output logic                   busy,
  output logic                   last_tick,
  output logic                   end_of_line,
  output logic                   end_of_frame,
  output logic                   frame_done
);

  // state      | meaning
  // S_IDLE     | waiting for start after reset or abort
  // S_COUNTING | advancing positions on enable using shadow limits
  // S_DONE     | frame finished (AUTO_RESTART=0), waiting for start
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COUNTING = 2'd1,
    S_DONE     = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [TICKS_WIDTH-1:0] ticks_nxt, max_ticks_r, max_ticks_nxt;
  logic [X_WIDTH-1:0]     x_nxt, max_x_r, max_x_nxt;
  logic [Y_WIDTH-1:0]     y_nxt, max_y_r, max_y_nxt;
  logic [Y_WIDTH-1:0]     y_init, y_step;
  logic                   y_last;
  logic                   frame_done_nxt;
  logic                   load;

`ifdef ALT_VIPVFR_RASTER_FIELD_EN
  // Field scan: y starts at the field parity and steps by two lines.
  assign y_init = Y_WIDTH'(field);
  assign y_step = Y_WIDTH'(2);
  assign y_last = ({1'b0, y} + (Y_WIDTH+1)'(2)) > {1'b0, max_y_r};
`else
  assign y_init = '0;
  assign y_step = Y_WIDTH'(1);
  assign y_last = (y >= max_y_r);
`endif

  assign busy         = (state == S_COUNTING);
  assign last_tick    = busy && (ticks >= max_ticks_r);
  assign end_of_line  = last_tick && (x >= max_x_r);
  assign end_of_frame = end_of_line && y_last;

  always_comb begin
    state_nxt      = state;
    ticks_nxt      = ticks;
    x_nxt          = x;
    y_nxt          = y;
    max_ticks_nxt  = max_ticks_r;
    max_x_nxt      = max_x_r;
    max_y_nxt      = max_y_r;
    frame_done_nxt = 1'b0;
    load           = 1'b0;

    if (abort) begin
      state_nxt = S_IDLE;
      ticks_nxt = '0;
      x_nxt     = '0;
      y_nxt     = '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            load      = 1'b1;
            state_nxt = S_COUNTING;
          end
        end
        S_COUNTING: begin
          if (enable) begin
            if (last_tick) begin
              ticks_nxt = '0;
              if (end_of_line) begin
                x_nxt = '0;
                if (end_of_frame) begin
                  y_nxt          = '0;
                  frame_done_nxt = 1'b1;
                  if (AUTO_RESTART != 0) load = 1'b1;
                  else                   state_nxt = S_DONE;
                end else begin
                  y_nxt = y + y_step;
                end
              end else begin
                x_nxt = x + X_WIDTH'(1);
              end
            end else begin
              ticks_nxt = ticks + TICKS_WIDTH'(1);
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase

      // Start of a frame (explicit or auto-restart) snapshots the limit inputs.
      if (load) begin
        max_ticks_nxt = max_ticks;
        max_x_nxt     = max_x;
        max_y_nxt     = max_y;
        ticks_nxt     = '0;
        x_nxt         = '0;
        y_nxt         = y_init;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ticks       <= '0;
      x           <= '0;
      y           <= '0;
      max_ticks_r <= '0;
      max_x_r     <= '0;
      max_y_r     <= '0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      ticks       <= ticks_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      max_ticks_r <= max_ticks_nxt;
      max_x_r     <= max_x_nxt;
      max_y_r     <= max_y_nxt;
      frame_done  <= frame_done_nxt;
    end
  end

endmodule

// File: doc/alt_vipvfr131_common_raster_count.md
Name: alt_vipvfr131_common_raster_count

Overview:
Parametrised three-level nested counter (ticks → x → y) that generates raster positions for frame reader/writer engines. It generalises the single-level tick/count counter with a full line and frame dimension, runtime limits shadowed per frame, and an idle/count/done state machine with start/abort control. Position flags (last tick, end of line, end of frame) drive address generators and packet framing in the frame reader datapath.

Parameters:
TICKS_WIDTH, 2, width of tick (sub-pixel/colour-plane) counter
X_WIDTH, 12, width of column counter
Y_WIDTH, 12, width of line counter
AUTO_RESTART, 0, 1 = start next frame immediately on frame end using current limit inputs; 0 = stop in DONE

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin a frame (honoured in IDLE or DONE)
abort  in  1  synchronous abort to IDLE, highest priority
enable  in  1  advance one tick this cycle (only while COUNTING)
max_ticks  in  TICKS_WIDTH  ticks per pixel minus 1
max_x  in  X_WIDTH  pixels per line minus 1
max_y  in  Y_WIDTH  lines per frame minus 1
ticks  out  TICKS_WIDTH  current tick index
x  out  X_WIDTH  current column
y  out  Y_WIDTH  current line
busy  out  1  state is COUNTING
last_tick  out  1  busy && ticks >= max_ticks_r
end_of_line  out  1  last_tick && x >= max_x_r
end_of_frame  out  1  end_of_line && y >= max_y_r
frame_done  out  1  registered one-cycle pulse after final advance of a frame

Behaviour:
- One clock domain clk; reset is asynchronous, active-low on reset_n.
- Reset: state IDLE, ticks/x/y = 0, shadow limits = 0, frame_done = 0; busy and all flags therefore 0.
- States: IDLE, COUNTING, DONE (2-bit encoding).
- IDLE/DONE + start: latch max_ticks/max_x/max_y into shadow regs, clear ticks/x/y, go COUNTING next cycle. No advance on the start cycle.
- COUNTING: start ignored; limit inputs ignored (only shadow regs used).
- Advance (COUNTING && enable): if ticks >= max_ticks_r, ticks←0 and carry to x; else ticks+1. On carry: x >= max_x_r → x←0 and carry to y; else x+1. On y carry (end_of_frame advance): frame complete.
- Use >= comparisons so a corrupted/oversized count still wraps. All increments are modulo width; no overflow past limits.
- Frame complete, AUTO_RESTART=0: counters←0, state→DONE, frame_done=1 for exactly one cycle.
- Frame complete, AUTO_RESTART=1: counters←0, relatch shadow limits from inputs, stay COUNTING, frame_done pulse; no idle cycle between frames.
- enable low in COUNTING: all counters hold; flags remain valid (combinational from regs).
- abort: any state → IDLE next cycle, counters←0, frame_done←0; overrides start, enable and frame completion in the same cycle.
- Limits of 0: max_ticks=0 → every enabled cycle advances x; all zero → 1-tick frame, end_of_frame high as soon as COUNTING.
- Latency: flags are combinational from registered counts; frame_done lags the final advance by one cycle.

Optional Feature:
ALT_VIPVFR_RASTER_FIELD_EN: adds input field (1 bit). At start (and auto-restart relatch), field is latched; y initialises to field, y carry adds 2, frame ends when y+2 > max_y_r (interlaced field scan of a frame-height limit). Without the macro: no field port, y starts at 0 and steps by 1.

Test Plan:
- Reset with start=1, enable=1 held → outputs all 0, state IDLE until reset_n high; then frame starts.
- max_ticks=1, max_x=2, max_y=1, start then enable constant → 12 advances; sequence (t,x,y) 0,0,0→1,0,0→0,1,0…; end_of_line at x=2,t=1; end_of_frame at cycle 12; frame_done pulse next cycle; busy=0 (DONE).
- Same config, enable toggling 1/0 → counts hold on 0 cycles; frame_done after 24 cycles; limit inputs changed mid-frame to 3 → no effect until next start.
- AUTO_RESTART=1, max_x=3, others 0, enable constant → x 0,1,2,3,0,1…, frame_done every 4th cycle +1, busy never drops.
- abort asserted at x=2 with enable=1 and start=1 → next cycle IDLE, x=0, no frame_done.
- FIELD_EN, max_y=5, field=1, max_x=max_ticks=0 → y sequence 1,3,5, end_of_frame at y=5; field=0 → 0,2,4.
